// File: rtl/ucsbece154b_mem_arbiter.sv
// Two-requester memory arbiter: pushes the granted block address into the shared request FIFO
// and steers burst responses back to the requester that issued them. Optional macro: UCSBECE154B_ARB_FIXED_PRIO_EN.
module ucsbece154b_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BLOCK_WORDS     = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req0_valid_i,
  input  logic [ADDR_WIDTH-1:0]              req0_addr_i,
  output logic                               req0_ready_o,
  input  logic                               req1_valid_i,
  input  logic [ADDR_WIDTH-1:0]              req1_addr_i,
  output logic                               req1_ready_o,
  output logic                               fifo_push_o,
  output logic [ADDR_WIDTH-1:0]              fifo_data_o,
  input  logic                               fifo_full_i,
  input  logic                               rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]              rsp_data_i,
  output logic                               rsp0_valid_o,
  output logic                               rsp1_valid_o,
  output logic [DATA_WIDTH-1:0]              rsp_data_o,
  output logic                               rsp_last_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = $clog2(BLOCK_WORDS);
  localparam int unsigned OW = PW + 1;
  localparam logic [OW-1:0] MAX_CNT   = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BLOCK_WORDS - 1);

  logic          id_q [MAX_OUTSTANDING];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          last_grant_q, last_grant_d;
  logic          err_q, err_d;

  logic can_issue, gnt0, gnt1, push, q_empty, beat_ok, pop;

  always_comb begin
    q_empty   = (cnt_q == '0);
    // Grants are suppressed while reset is held so every handshake output reads 0.
    can_issue = !rst_i && !fifo_full_i && (cnt_q < MAX_CNT);
`ifdef UCSBECE154B_ARB_FIXED_PRIO_EN
    gnt1 = can_issue && req1_valid_i;
    gnt0 = can_issue && req0_valid_i && !req1_valid_i;
`else
    gnt0 = can_issue && req0_valid_i && (!req1_valid_i || last_grant_q);
    gnt1 = can_issue && req1_valid_i && (!req0_valid_i || !last_grant_q);
`endif
    push = gnt0 || gnt1;

    beat_ok = rsp_valid_i && !q_empty;
    pop     = beat_ok && (beat_q == LAST_BEAT);
  end

  assign req0_ready_o  = gnt0;
  assign req1_ready_o  = gnt1;
  assign fifo_push_o   = push;
  assign fifo_data_o   = gnt1 ? req1_addr_i : (gnt0 ? req0_addr_i : '0);
  assign rsp0_valid_o  = beat_ok && !id_q[head_q];
  assign rsp1_valid_o  = beat_ok && id_q[head_q];
  assign rsp_data_o    = rsp_data_i;
  assign rsp_last_o    = pop;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    err_d        = err_q || (rsp_valid_i && q_empty);

    if (pop)  head_d = head_q + PW'(1);
    if (push) begin
      tail_d       = tail_q + PW'(1);
      last_grant_d = gnt1;
    end
    if (push && !pop)      cnt_d = cnt_q + OW'(1);
    else if (pop && !push) cnt_d = cnt_q - OW'(1);

    if (beat_ok) beat_d = pop ? '0 : beat_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      beat_q       <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) id_q[i] <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      if (push) id_q[tail_q] <= gnt1;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Bench for ucsbece154b_mem_arbiter: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of in-flight request IDs.
module tb_ucsbece154b_mem_arbiter;

  localparam int BW  = 4;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_addr, req1_addr, fifo_data, rsp_data_in, rsp_data_out;
  logic        fifo_push, fifo_full, rsp_valid, rsp0_valid, rsp1_valid, rsp_last, err;
  logic [2:0]  outstanding;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int idq[$];
  int beat;
  int last_gnt;
  bit err_m;

  ucsbece154b_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WORDS(BW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_addr_i(req1_addr), .req1_ready_o(req1_ready),
    .fifo_push_o(fifo_push), .fifo_data_o(fifo_data), .fifo_full_i(fifo_full),
    .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data_in),
    .rsp0_valid_o(rsp0_valid), .rsp1_valid_o(rsp1_valid), .rsp_data_o(rsp_data_out),
    .rsp_last_o(rsp_last), .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check outputs against the model, then
  // advance the model to what the following rising edge should produce.
  task automatic step(input bit r, input bit v0, input logic [31:0] a0,
                      input bit v1, input logic [31:0] a1, input bit full,
                      input bit rv, input logic [31:0] rd,
                      output bit g0, output bit g1);
    bit can, bv, lst, r0, r1;
    logic [31:0] fd;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
    fifo_full = full; rsp_valid = rv; rsp_data_in = rd;
    #1;
    if (r) begin
      idq.delete(); beat = 0; last_gnt = 1; err_m = 0;
    end
    can = !r && !full && (idq.size() < MAX);
    g0 = 0; g1 = 0;
    if (can && v0 && v1) begin
`ifdef UCSBECE154B_ARB_FIXED_PRIO_EN
      g1 = 1;
`else
      if (last_gnt == 0) g1 = 1; else g0 = 1;
`endif
    end else if (can && v0) g0 = 1;
    else if (can && v1) g1 = 1;
    fd  = g0 ? a0 : (g1 ? a1 : 32'h0);
    bv  = rv && (idq.size() > 0);
    r0  = bv && (idq[0] == 0);
    r1  = bv && (idq[0] == 1);
    lst = bv && (beat == BW - 1);

    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    check("fifo_push", fifo_push, g0 || g1);
    check("fifo_data", fifo_data, fd);
    check("rsp0_valid", rsp0_valid, r0);
    check("rsp1_valid", rsp1_valid, r1);
    check("rsp_last", rsp_last, lst);
    check("rsp_data", rsp_data_out, rd);
    check("outstanding", outstanding, idq.size());
    check("err", err, err_m);

    if (!r) begin
      if (rv && idq.size() == 0) err_m = 1;
      if (bv) begin
        if (beat == BW - 1) begin beat = 0; void'(idq.pop_front()); end
        else beat++;
      end
      if (g0 || g1) begin
        idq.push_back(g1 ? 1 : 0);
        last_gnt = g1 ? 1 : 0;
      end
    end
  endtask

  initial begin
    bit g0, g1, p0, p1, r, rv;
    logic [31:0] a0, a1;
    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
    fifo_full = 0; rsp_valid = 0; rsp_data_in = '0;
    idq.delete(); beat = 0; last_gnt = 1; err_m = 0;

    // Reset with requesters active: nothing may be granted
    step(1, 1, 32'h100, 1, 32'h200, 0, 1, 32'h55, g0, g1);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, g0, g1);

    // Round robin to saturation, then stall
    for (int i = 0; i < 6; i++) step(0, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0, g0, g1);
    check("saturated_outstanding", outstanding, 3'd4);
    for (int i = 0; i < MAX * BW; i++) step(0, 0, 0, 0, 0, 0, 1, $urandom, g0, g1);

    // Two bursts routed to their issuers
    step(0, 1, 32'h40, 0, 0, 0, 0, 32'h0, g0, g1);
    step(0, 0, 0, 1, 32'h80, 0, 0, 32'h0, g0, g1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1, 32'hA0 + 32'(i), g0, g1);

    // FIFO full blocks the grant; grant as soon as it clears
    for (int i = 0; i < 3; i++) step(0, 1, 32'h300, 0, 0, 1, 0, 32'h0, g0, g1);
    step(0, 1, 32'h300, 0, 0, 0, 0, 32'h0, g0, g1);

    // Grant concurrent with the head burst's last beat
    for (int i = 0; i < BW - 1; i++) step(0, 0, 0, 0, 0, 0, 1, $urandom, g0, g1);
    step(0, 0, 0, 1, 32'h400, 0, 1, 32'h77, g0, g1);
    check("pushpop_outstanding", outstanding, 3'd1);
    for (int i = 0; i < BW; i++) step(0, 0, 0, 0, 0, 0, 1, $urandom, g0, g1);

    // Beat with an empty queue: sticky error
    step(0, 0, 0, 0, 0, 0, 1, 32'hDEAD, g0, g1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h0, g0, g1);
    check("err_sticky", err, 1'b1);

    // Reset mid-burst, then tie-break and orphaned beats
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, g0, g1);
    step(0, 1, 32'h500, 0, 0, 0, 0, 32'h0, g0, g1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h1, g0, g1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h2, g0, g1);
    step(1, 0, 0, 0, 0, 0, 1, 32'h3, g0, g1);
    step(0, 1, 32'h600, 1, 32'h700, 0, 0, 32'h0, g0, g1);
`ifdef UCSBECE154B_ARB_FIXED_PRIO_EN
    check("post_reset_winner1", req1_ready, 1'b1);
`else
    check("post_reset_winner0", req0_ready, 1'b1);
`endif
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, g0, g1);

    // Randomized traffic; requesters hold valid/addr until granted
    p0 = 0; p1 = 0; a0 = '0; a1 = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!p0 && ($urandom % 3 == 0)) begin p0 = 1; a0 = $urandom; end
      if (!p1 && ($urandom % 3 == 0)) begin p1 = 1; a1 = $urandom; end
      r  = ($urandom % 250 == 0);
      rv = (idq.size() > 0) ? bit'($urandom % 2) : ($urandom % 100 == 0);
      step(r, p0, a0, p1, a1, ($urandom % 5 == 0), rv, $urandom, g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
